// File: rtl/mem_wait_gen.sv
// Wait-state generator for an asynchronous CPU bus: inserts a per-region number of PHI-cycle waits.
// Define MEM_WAIT_GEN_IO_EN to also insert waits on I/O cycles; otherwise only memory cycles are seen.
module mem_wait_gen #(
    parameter int unsigned MEM_WAITS = 1,
    parameter int unsigned ROM_WAITS = 0,
    parameter int unsigned IO_WAITS  = 2,
    parameter logic [19:0] ROM_TOP   = 20'h200
) (
    input  logic        hwclk,
    input  logic        reset_n,
    input  logic        phi,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        m1_n,
    input  logic [19:0] a,
    output logic        wait_n,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] MEM_CNT = 4'(MEM_WAITS);
    localparam logic [3:0] ROM_CNT = 4'(ROM_WAITS);

    logic       r_phi_s1, r_phi_s2, r_phi_d;
    logic       r_mreq_s1, r_mreq_s2, r_mreq_d;
    state_t     r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic       r_wait_n, w_wait_nxt;

    logic       w_phi_fall;
    logic       w_mem_start;
    logic       w_io_start;
    logic       w_start;
    logic       w_release;
    logic [3:0] w_io_cnt;
    logic [3:0] w_sel_cnt;

    // The _d flops hold the previous synchronized level for edge detection.
    always_ff @(posedge hwclk) begin
        if (!reset_n) begin
            r_phi_s1  <= 1'b0;
            r_phi_s2  <= 1'b0;
            r_phi_d   <= 1'b0;
            r_mreq_s1 <= 1'b1;
            r_mreq_s2 <= 1'b1;
            r_mreq_d  <= 1'b1;
        end else begin
            r_phi_s1  <= phi;
            r_phi_s2  <= r_phi_s1;
            r_phi_d   <= r_phi_s2;
            r_mreq_s1 <= mreq_n;
            r_mreq_s2 <= r_mreq_s1;
            r_mreq_d  <= r_mreq_s2;
        end
    end

    assign w_phi_fall  = r_phi_d & ~r_phi_s2;
    assign w_mem_start = r_mreq_d & ~r_mreq_s2;

`ifdef MEM_WAIT_GEN_IO_EN
    localparam logic [3:0] IO_CNT = 4'(IO_WAITS);

    logic r_iorq_s1, r_iorq_s2, r_iorq_d;
    logic r_m1_s1, r_m1_s2;

    always_ff @(posedge hwclk) begin
        if (!reset_n) begin
            r_iorq_s1 <= 1'b1;
            r_iorq_s2 <= 1'b1;
            r_iorq_d  <= 1'b1;
            r_m1_s1   <= 1'b1;
            r_m1_s2   <= 1'b1;
        end else begin
            r_iorq_s1 <= iorq_n;
            r_iorq_s2 <= r_iorq_s1;
            r_iorq_d  <= r_iorq_s2;
            r_m1_s1   <= m1_n;
            r_m1_s2   <= r_m1_s1;
        end
    end

    // /IORQ with /M1 low is an interrupt acknowledge, never a wait-state cycle.
    assign w_io_start = r_iorq_d & ~r_iorq_s2 & r_m1_s2;
    assign w_release  = r_mreq_s2 & r_iorq_s2;
    assign w_io_cnt   = IO_CNT;
`else
    logic w_unused_io;
    assign w_unused_io = &{1'b0, iorq_n, m1_n, IO_WAITS[0]};
    assign w_io_start  = 1'b0;
    assign w_release   = r_mreq_s2;
    assign w_io_cnt    = 4'd0;
`endif

    assign w_start   = w_mem_start | w_io_start;
    assign w_sel_cnt = w_mem_start ? ((a < ROM_TOP) ? ROM_CNT : MEM_CNT) : w_io_cnt;

    always_ff @(posedge hwclk) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_wait_n <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_wait_n <= w_wait_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wait_nxt  = r_wait_n;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    if (w_sel_cnt != 4'd0) begin
                        w_state_nxt = COUNT;
                        w_cnt_nxt   = w_sel_cnt;
                        w_wait_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = HOLD;
                    end
                end
            end
            COUNT: begin
                // An aborted cycle wins over a coincident PHI edge.
                if (w_release) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 4'd0;
                    w_wait_nxt  = 1'b1;
                end else if (w_phi_fall) begin
                    if (r_cnt <= 4'd1) begin
                        w_state_nxt = HOLD;
                        w_cnt_nxt   = 4'd0;
                        w_wait_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
            end
            HOLD: begin
                if (w_release) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
                w_wait_nxt  = 1'b1;
            end
        endcase
    end

    assign wait_n = r_wait_n;
    assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_mem_wait_gen.sv
// Bench for mem_wait_gen: directed vector table, randomized bus cycles against a pin-history model,
// plus hand sequences for abort and mid-count reset.
module tb_mem_wait_gen;
    localparam int MAXT = 20000;
`ifdef MEM_WAIT_GEN_IO_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif
    localparam logic [19:0] ROM_TOP = 20'h200;
    localparam int ROM_W = 0;
    localparam int IO_W  = 2;

    logic        hwclk = 1'b0;
    logic        reset_n, phi, mreq_n, iorq_n, m1_n;
    logic [19:0] a;
    logic        w0, b0, w15, b15, w3, b3;

    always #5 hwclk = ~hwclk;

    mem_wait_gen dut (
        .hwclk(hwclk), .reset_n(reset_n), .phi(phi), .mreq_n(mreq_n), .iorq_n(iorq_n),
        .m1_n(m1_n), .a(a), .wait_n(w0), .busy(b0)
    );
    mem_wait_gen #(.MEM_WAITS(15)) dut15 (
        .hwclk(hwclk), .reset_n(reset_n), .phi(phi), .mreq_n(mreq_n), .iorq_n(iorq_n),
        .m1_n(m1_n), .a(a), .wait_n(w15), .busy(b15)
    );
    mem_wait_gen #(.MEM_WAITS(3)) dut3 (
        .hwclk(hwclk), .reset_n(reset_n), .phi(phi), .mreq_n(mreq_n), .iorq_n(iorq_n),
        .m1_n(m1_n), .a(a), .wait_n(w3), .busy(b3)
    );

    // Pin history indexed by the hwclk edge the value was presented to; cf = cumulative phi falls.
    bit          mreq_h [MAXT];
    bit          iorq_h [MAXT];
    bit          m1_h   [MAXT];
    bit          phi_h  [MAXT];
    logic [19:0] a_h    [MAXT];
    int          cf     [MAXT];

    int tick       = 0;
    int model_base = 0;
    bit model_en   = 1'b0;
    bit phi_run    = 1'b0;
    int phi_left   = 3;
    int n_checks   = 0;
    int n_pass     = 0;

    typedef struct {
        bit          rst_n;
        bit          phi;
        bit          mreq;
        bit          iorq;
        bit          m1;
        logic [19:0] addr;
        bit          w;
        bit          b;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s tick=%0d actual=%0d required=%0d", name, tick, act, exp);
    endtask

    // Outputs after edge e reflect the pins as presented two edges earlier: a cycle is active from
    // its start until a release; wait_n is low while fewer than N phi falls have occurred since start.
    function automatic void model(input int e, input int memw, output bit w, output bit b);
        int k, t0, n, falls;
        bit found;
        w = 1'b1;
        b = 1'b0;
        k = e - 2;
        found = 1'b0;
        t0 = 0;
        if (k <= model_base) return;
        for (int t = k; t > model_base; t--) begin
            if (mreq_h[t] && (!IO_EN || iorq_h[t])) break;
            if ((mreq_h[t-1] && !mreq_h[t]) ||
                (IO_EN && iorq_h[t-1] && !iorq_h[t] && m1_h[t])) begin
                found = 1'b1;
                t0 = t;
                break;
            end
        end
        if (!found) return;
        b = 1'b1;
        if (mreq_h[t0-1] && !mreq_h[t0]) n = (a_h[t0+2] < ROM_TOP) ? ROM_W : memw;
        else n = IO_W;
        falls = cf[k] - cf[t0];
        w = !(n > 0 && falls < n);
    endfunction

    task automatic step();
        bit we, be;
        if (phi_run) begin
            if (phi_left <= 1) begin
                phi = ~phi;
                phi_left = $urandom_range(2, 5);
            end else begin
                phi_left--;
            end
        end
        tick++;
        if (tick >= MAXT) begin
            $display("FAIL history_overflow tick=%0d limit=%0d", tick, MAXT);
            $fatal(1);
        end
        mreq_h[tick] = mreq_n;
        iorq_h[tick] = iorq_n;
        m1_h[tick]   = m1_n;
        phi_h[tick]  = phi;
        a_h[tick]    = a;
        cf[tick]     = cf[tick-1] + ((phi_h[tick-1] && !phi_h[tick]) ? 1 : 0);
        @(posedge hwclk);
        @(negedge hwclk);
        if (model_en) begin
            model(tick, 1, we, be);
            check("m_wait_w1", w0, we);   check("m_busy_w1", b0, be);
            model(tick, 15, we, be);
            check("m_wait_w15", w15, we); check("m_busy_w15", b15, be);
            model(tick, 3, we, be);
            check("m_wait_w3", w3, we);   check("m_busy_w3", b3, be);
        end
    endtask

    function automatic logic wsel(input int inst);
        case (inst)
            0:       return w0;
            1:       return w15;
            default: return w3;
        endcase
    endfunction

    task automatic tv(input bit r, input bit p, input bit mq, input bit io, input bit m1,
                      input logic [19:0] ad, input bit w, input bit b);
        vec_t v;
        v = '{r, p, mq, io, m1, ad, w, b};
        tbl.push_back(v);
    endtask

    // One cycle: latency to wait_n low, then phi falls counted until wait_n releases.
    task automatic measure(input string name, input int inst, input bit io,
                           input logic [19:0] addr, input int exp_n);
        int t0;
        bit ok;
        repeat (4) step();
        a = addr;
        if (io) begin
            iorq_n = 1'b0;
            m1_n   = 1'b1;
        end else begin
            mreq_n = 1'b0;
        end
        step();
        t0 = tick;
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (wsel(inst) == 1'b0) begin ok = 1'b1; break; end
            step();
        end
        if (!ok) begin
            $display("FAIL %s_low_timeout actual=never required=low", name);
            n_checks++;
        end else begin
            check({name, "_latency"}, tick - t0, 2);
            ok = 1'b0;
            for (int i = 0; i < 250; i++) begin
                step();
                if (wsel(inst) == 1'b1) begin ok = 1'b1; break; end
            end
            if (!ok) begin
                $display("FAIL %s_release_timeout actual=low required=high", name);
                n_checks++;
            end else begin
                check({name, "_phi_falls"}, cf[tick-2] - cf[t0], exp_n);
            end
        end
        repeat (2) step();
        mreq_n = 1'b1;
        iorq_n = 1'b1;
        m1_n   = 1'b1;
        repeat (4) step();
    endtask

    initial begin
        int f0;
        bit ok;
        reset_n = 1'b0; phi = 1'b0; mreq_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1; a = '0;

        tv(0,0,1,1,1,20'h00000, 1,0); tv(0,0,1,1,1,20'h00000, 1,0);
        tv(1,0,1,1,1,20'h00000, 1,0); tv(1,0,1,1,1,20'h00000, 1,0);
        tv(1,0,0,1,1,20'h00100, 1,0); tv(1,0,0,1,1,20'h00100, 1,0);
        tv(1,0,0,1,1,20'h00100, 1,1); tv(1,0,1,1,1,20'h00100, 1,1);
        tv(1,0,1,1,1,20'h00100, 1,1); tv(1,0,1,1,1,20'h00000, 1,0);
        tv(1,1,0,1,1,20'h08000, 1,0); tv(1,1,0,1,1,20'h08000, 1,0);
        tv(1,1,0,1,1,20'h08000, 0,1); tv(1,1,0,1,1,20'h08000, 0,1);
        tv(1,0,0,1,1,20'h08000, 0,1); tv(1,0,0,1,1,20'h08000, 0,1);
        tv(1,0,0,1,1,20'h08000, 1,1); tv(1,0,1,1,1,20'h08000, 1,1);
        tv(1,0,1,1,1,20'h08000, 1,1); tv(1,0,1,1,1,20'h00000, 1,0);
        for (int i = 0; i < 5; i++) tv(1,0,1,0,0,20'h00000, 1,0);
        tv(1,0,1,1,1,20'h00000, 1,0); tv(1,0,1,1,1,20'h00000, 1,0);

        for (int i = 0; i < tbl.size(); i++) begin
            reset_n = tbl[i].rst_n; phi = tbl[i].phi; mreq_n = tbl[i].mreq;
            iorq_n = tbl[i].iorq; m1_n = tbl[i].m1; a = tbl[i].addr;
            step();
            check($sformatf("tbl%0d_wait", i), w0, tbl[i].w);
            check($sformatf("tbl%0d_busy", i), b0, tbl[i].b);
        end

        phi_run = 1'b1;
        repeat (4) step();
        model_base = tick;
        model_en = 1'b1;

        for (int n = 0; n < 150; n++) begin
            int kind, reg_sel;
            repeat ($urandom_range(3, 8)) step();
            reg_sel = $urandom_range(0, 3);
            case (reg_sel)
                0:       a = 20'h001FF;
                1:       a = 20'h00200;
                2:       a = 20'($urandom_range(0, 32'h1FF));
                default: a = 20'($urandom_range(32'h200, 32'hFFFFF));
            endcase
            kind = $urandom_range(0, 3);
            case (kind)
                0, 1: mreq_n = 1'b0;
                2:    begin iorq_n = 1'b0; m1_n = 1'b1; end
                default: begin iorq_n = 1'b0; m1_n = 1'b0; end
            endcase
            repeat ($urandom_range(2, 50)) step();
            mreq_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1;
        end

        measure("mem_w1", 0, 1'b0, 20'h08000, 1);
        measure("mem_w3", 2, 1'b0, 20'h00400, 3);
`ifdef MEM_WAIT_GEN_IO_EN
        measure("io_w2", 0, 1'b1, 20'h00040, 2);
`endif

        // Aborted cycle: /MREQ released after one phi fall.
        repeat (4) step();
        a = 20'h08000;
        mreq_n = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (w3 == 1'b0) begin ok = 1'b1; break; end
        end
        check("abort_wait_low", ok, 1);
        f0 = cf[tick];
        for (int i = 0; i < 20 && cf[tick] == f0; i++) step();
        check("abort_wait_before", w3, 0);
        mreq_n = 1'b1;
        repeat (3) step();
        check("abort_wait", w3, 1);
        check("abort_busy", b3, 0);
        repeat (4) step();

        // Reset part-way through a 15-wait count.
        a = 20'h08000;
        mreq_n = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (w15 == 1'b0) begin ok = 1'b1; break; end
        end
        check("rst_wait_low", ok, 1);
        f0 = cf[tick];
        for (int i = 0; i < 60 && cf[tick] < f0 + 5; i++) step();
        check("rst_falls_seen", cf[tick] - f0, 5);
        check("rst_pre_wait", w15, 0);
        model_en = 1'b0;
        reset_n = 1'b0;
        mreq_n = 1'b1;
        step();
        check("rst_wait", w15, 1);
        check("rst_busy", b15, 0);
        reset_n = 1'b1;
        repeat (4) step();
        check("rst_idle_busy", b15, 0);
        model_base = tick;
        model_en = 1'b1;
        measure("full15", 1, 1'b0, 20'h08000, 15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
